// File: rtl/puf_mapping_pkg.sv
// Shared definitions for the challenge-to-response mapper and its PUF core.
package puf_mapping_pkg;

   // Default geometry: 128-bit challenge folded into a 16-bit response.
   localparam int unsigned DefInWidth  = 128;
   localparam int unsigned DefOutWidth = 16;

   // Mapper control states.
   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StWait,
      StDone
   } state_e;

   // Rotation distance between consecutive sub-challenges.
   function automatic int unsigned calc_step(input int unsigned in_w, input int unsigned out_w);
      return in_w / out_w;
   endfunction

   // Number of accumulate steps the core performs per evaluation.
   function automatic int unsigned calc_half(input int unsigned in_w);
      return in_w / 2;
   endfunction

   // Cycles per slot: start pulse, HALF accumulate steps, valid cycle.
   function automatic int unsigned calc_period(input int unsigned in_w);
      return (in_w / 2) + 2;
   endfunction

   localparam int unsigned Step   = calc_step(DefInWidth, DefOutWidth);
   localparam int unsigned Half   = calc_half(DefInWidth);
   localparam int unsigned Period = calc_period(DefInWidth);

endpackage

// File: rtl/puf_core.sv
// Deterministic arbiter-race surrogate: compares the ones-count of the low and
// high challenge halves one bit pair per cycle, then reports the winner.
module puf_core
   import puf_mapping_pkg::*;
#(
   parameter int unsigned W = DefInWidth
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [W-1:0] chal_i,
   output logic         valid_o,
   output logic         bit_o
);

   localparam int unsigned HalfW = calc_half(W);
   localparam int unsigned CntW  = (HalfW > 1) ? $clog2(HalfW) : 1;
   localparam int unsigned AccW  = $clog2(HalfW) + 2;

   logic [W-1:0]           chal_q;
   logic                   busy_q;
   logic                   valid_q;
   logic                   bit_q;
   logic [CntW-1:0]        cnt_q;
   logic signed [AccW-1:0] acc_q;

   logic [HalfW-1:0]       chal_lo;
   logic [HalfW-1:0]       chal_hi;
   logic signed [AccW-1:0] acc_d;
   logic                   last_step;
   logic                   win;

   assign chal_lo = chal_q[HalfW-1:0];
   assign chal_hi = chal_q[W-1:HalfW];

   // One race step: +1 for a low-half one, -1 for the paired high-half one.
   always_comb begin
      acc_d     = acc_q + AccW'(chal_lo[cnt_q]) - AccW'(chal_hi[cnt_q]);
      last_step = (cnt_q == CntW'(HalfW - 1));
      // Strictly positive wins; ties resolve to 0.
      win       = !acc_d[AccW-1] && (acc_d != '0);
   end

   // Evaluation sequencer; start is ignored while an evaluation is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         chal_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         bit_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         if (!busy_q) begin
            if (start_i) begin
               chal_q <= chal_i;
               busy_q <= 1'b1;
               cnt_q  <= '0;
               acc_q  <= '0;
            end
         end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CntW'(1);
            if (last_step) begin
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
               bit_q   <= win;
            end
         end
      end
   end

   assign valid_o = valid_q;
   assign bit_o   = bit_q;

endmodule

// File: rtl/puf_mapping.sv
// Challenge-to-response mapper: latches a challenge, evaluates OUT_WIDTH
// rotated sub-challenges on the PUF core one after another, and assembles the
// response bits. Waits on the core's valid, so core latency may change.
module puf_mapping
   import puf_mapping_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = DefInWidth,
   parameter int unsigned OUT_WIDTH = DefOutWidth
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 trigger,
   input  logic [IN_WIDTH-1:0]  dataIn,
   output logic                 done,
   output logic [OUT_WIDTH-1:0] dataOut
);

   localparam int unsigned SlotStep = calc_step(IN_WIDTH, OUT_WIDTH);
   localparam int unsigned KW       = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
   localparam int unsigned ShW      = $clog2(IN_WIDTH) + 1;

   state_e                 state_q;
   logic [IN_WIDTH-1:0]    chal_q;
   logic [KW-1:0]          k_q;
   logic [OUT_WIDTH-1:0]   data_q;
   logic                   done_q;
   logic                   start_q;

   logic [ShW-1:0]         rot_amt;
   logic [IN_WIDTH-1:0]    chal_rot;
   logic                   core_valid;
   logic                   core_bit;

   // Sub-challenge k is the latched challenge rotated left by k*SlotStep.
   // A zero rotation shifts the right-hand term by the full width, giving 0.
   always_comb begin
      rot_amt  = ShW'(k_q) * ShW'(SlotStep);
      chal_rot = (chal_q << rot_amt) | (chal_q >> (ShW'(IN_WIDTH) - rot_amt));
   end

   puf_core #(
      .W (IN_WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .start_i (start_q),
      .chal_i  (chal_rot),
      .valid_o (core_valid),
      .bit_o   (core_bit)
   );

   // Control FSM; start and done are registered so they align with RUN/DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         chal_q  <= '0;
         k_q     <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (trigger) begin
                  chal_q  <= dataIn;
                  k_q     <= '0;
                  data_q  <= '0;
                  start_q <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               state_q <= StWait;
            end
            StWait: begin
               if (core_valid) begin
                  data_q[k_q] <= core_bit;
                  if (k_q == KW'(OUT_WIDTH - 1)) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     k_q     <= k_q + KW'(1);
                     start_q <= 1'b1;
                     state_q <= StRun;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign done    = done_q;
   assign dataOut = data_q;

endmodule

// File: tb/tb_puf_mapping.sv
// Self-checking bench for puf_mapping: table-driven vectors plus hand-written
// sequences for re-trigger, ignored triggers and mid-run reset.
module tb_puf_mapping;
   import puf_mapping_pkg::*;

   localparam int unsigned InW     = DefInWidth;
   localparam int unsigned OutW    = DefOutWidth;
   localparam int          Latency = 1 + int'(OutW * Period);

   logic            clk = 1'b0;
   logic            reset;
   logic            trigger;
   logic [InW-1:0]  dataIn;
   logic            done;
   logic [OutW-1:0] dataOut;

   puf_mapping #(
      .IN_WIDTH  (InW),
      .OUT_WIDTH (OutW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .trigger (trigger),
      .dataIn  (dataIn),
      .done    (done),
      .dataOut (dataOut)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   typedef struct {
      logic [OutW-1:0] data;
      int              cycle;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [InW-1:0]  din;
      logic [OutW-1:0] dout;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Independent reference: rotl(x,r)[i] = x[(i-r) mod W], then ones(low) - ones(high) > 0.
   function automatic logic [OutW-1:0] model(input logic [InW-1:0] c);
      logic [OutW-1:0] r;
      r = '0;
      for (int k = 0; k < int'(OutW); k++) begin
         int acc;
         int sh;
         acc = 0;
         sh  = k * int'(InW / OutW);
         for (int i = 0; i < int'(InW); i++) begin
            int b;
            b = int'(c[(i - sh + int'(InW)) % int'(InW)]);
            if (i < int'(InW / 2)) acc += b;
            else acc -= b;
         end
         r[k] = (acc > 0);
      end
      return r;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
         end else begin
            e = sb_q.pop_front();
            check("dataOut", 128'(dataOut), 128'(e.data));
            check("done_cycle", 128'(cyc), 128'(e.cycle));
         end
      end
   end

   task automatic start_run(input logic [InW-1:0] d, input logic [OutW-1:0] e, output int t);
      exp_t x;
      @(negedge clk);
      t       = cyc;
      dataIn  = d;
      trigger = 1'b1;
      x.data  = e;
      x.cycle = cyc + Latency;
      sb_q.push_back(x);
      @(negedge clk);
      trigger = 1'b0;
      dataIn  = ~d;  // must not matter after the accept cycle
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: %0d results outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic pulse_at(input int c, input logic [InW-1:0] d);
      while (cyc < c) @(negedge clk);
      trigger = 1'b1;
      dataIn  = d;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   logic [InW-1:0] half_ones;
   logic [InW-1:0] rnd;

   initial begin
      int t;
      int base;
      half_ones = {{(InW/2){1'b0}}, {(InW/2){1'b1}}};

      vecs[0] = '{din: '0, dout: 16'h0000};
      vecs[1] = '{din: '1, dout: 16'h0000};
      vecs[2] = '{din: half_ones, dout: 16'hE00F};
      vecs[3] = '{din: ~half_ones, dout: 16'h0FE0};
      for (int i = 4; i < 6; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         vecs[i] = '{din: rnd, dout: model(rnd)};
      end

      reset   = 1'b1;
      trigger = 1'b0;
      dataIn  = '0;
      repeat (3) @(negedge clk);
      check("reset_done", 128'(done), 128'(0));
      check("reset_dataOut", 128'(dataOut), 128'(0));
      reset = 1'b0;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < 6; i++) begin
         start_run(vecs[i].din, vecs[i].dout, t);
         wait_idle(Latency + 20);
      end

      // Re-trigger shortly after done: output held, then identical result.
      start_run(half_ones, 16'hE00F, t);
      wait_idle(Latency + 20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_done", 128'(done), 128'(0));
         check("hold_dataOut", 128'(dataOut), 128'(16'hE00F));
      end
      start_run(half_ones, 16'hE00F, t);
      wait_idle(Latency + 20);

      // Triggers during a run, including in the DONE cycle, are ignored.
      base = n_done;
      start_run(half_ones, 16'hE00F, t);
      pulse_at(t + 3, '1);
      pulse_at(t + 600, '0);
      pulse_at(t + Latency, ~half_ones);
      repeat (1200) @(negedge clk);
      check("single_done", 128'(n_done - base), 128'(1));
      wait_idle(1);

      // Reset mid-run discards the partial response.
      base = n_done;
      start_run(half_ones, 16'hE00F, t);
      while (cyc < t + 500) @(negedge clk);
      check("partial_dataOut", 128'(dataOut), 128'(16'h000F));
      reset = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("midreset_done", 128'(done), 128'(0));
      check("midreset_dataOut", 128'(dataOut), 128'(0));
      reset = 1'b0;
      repeat (1200) @(negedge clk);
      check("no_done_after_reset", 128'(n_done - base), 128'(0));
      start_run(half_ones, 16'hE00F, t);
      wait_idle(Latency + 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
